dpb_port_arbiter: RTL and testbench
===================================

Name: dpb_port_arbiter

Overview:
- Shares port A of one DPB block RAM between two requesters (req0, req1) using round-robin arbitration.
- Registers one RAM command per CLKA cycle. Returns read data to the requester that issued the read, with fixed latency.
- Sits between client logic (e.g. a line buffer writer and a display reader) and the DPB instance. Port B of the DPB stays free for other use.

Parameters:
BIT_WIDTH, 16, DPB data width per word (1, 2, 4, 8 or 16); must equal the DPB BIT_WIDTH_0.
BLK_SEL, 3'b000, value driven on ram_blksel; must equal the DPB BLK_SEL_0.
DEPTH, 2**(14-$clog2(BIT_WIDTH)), number of RAM words (derived; do not override).

Ports:
CLKA  in  1  clock for all logic and for DPB CLKA
RESETB  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle
req0_we  in  1  1 = write, 0 = read
req0_addr  in  14  DPB-style bit address; low $clog2(BIT_WIDTH) bits are ignored
req0_wdata  in  16  write data; upper bits above BIT_WIDTH are ignored
rsp0_valid  out  1  read data valid for requester 0
rsp0_data  out  16  read data
req1_*, rsp1_*  same set as requester 0, for requester 1
ram_cea  out  1  to DPB CEA
ram_wrea  out  1  to DPB WREA
ram_ocea  out  1  to DPB OCEA; constant 1
ram_reseta  out  1  to DPB RESETA; constant 0
ram_ada  out  14  to DPB ADA
ram_dia  out  16  to DPB DIA
ram_blksel  out  3  to DPB BLKSELA; constant BLK_SEL
ram_doa  in  16  from DPB DOA
init_done  out  1  arbiter accepting requests

Behaviour:
- Reset (RESETB=1 at a CLKA edge): the following outputs are 0: ram_cea, ram_wrea, ram_ada, ram_dia, rsp0_valid, rsp1_valid, init_done. last_grant=1, so req0 wins first. Any read in flight is dropped; no rsp is issued for it.
- States: RST, CLEAR (optional feature only), RUN. RST goes to RUN on the first non-reset edge; init_done=1 in RUN.
- Arbitration is combinational, in RUN only:
  - One requester valid: it gets ready.
  - Both valid: grant the one != last_grant.
  - At most one ready per cycle. ready never depends on ready.
- Accept at edge k (valid & ready):
  - ram_cea=1, ram_wrea=we, ram_ada=addr, ram_dia=wdata are registered and held during cycle k..k+1.
  - last_grant is updated to the winner.
- No accept: ram_cea=0 next cycle. ram_ada/ram_dia hold their previous values.
- Read latency: DPB captures DOA at edge k+1. rsp<n>_valid=1 for exactly one cycle (k+1..k+2), and rsp<n>_data=ram_doa in that cycle.
  - Back-to-back reads give back-to-back responses, in order.
  - rsp_data is don't-care when rsp_valid=0.
- Writes produce no response. A read issued the cycle after a write to the same address returns the new data.
- A requester must hold valid/we/addr/wdata stable until ready.
- Throughput: one command per cycle. With both requesters continuously valid, grants alternate 0,1,0,1.

Optional Feature:
DPB_ARB_CLEAR_EN
- Defined:
  - After reset, enter CLEAR instead of RUN.
  - Write 0 to word addresses 0..DEPTH-1, one per cycle: ram_ada = idx << $clog2(BIT_WIDTH), ram_wrea=1, ram_cea=1.
  - Both ready outputs are held 0 throughout CLEAR.
  - After the last word, go to RUN; init_done rises the cycle after the final write command.
  - Reset during CLEAR restarts from idx 0.
- Not defined: CLEAR state and counter are absent; RST goes directly to RUN.

Test Plan:
1. Reset, then req0 writes addr 0x0010 data 0xBEEF, then reads 0x0010 -> req0_ready 1 each; rsp0_valid exactly 2 cycles after read accept with rsp0_data=0xBEEF; rsp1_valid stays 0.
2. req0 and req1 both valid reading 0x0000/0x0010 for 4 cycles -> grants 0,1,0,1; responses alternate rsp0/rsp1 with the correct per-address data.
3. req1 writes 0x0020=0x1234 and req0 reads 0x0020 in the same cycle, last_grant=0 -> write wins first; the read, accepted the next cycle, returns 0x1234.
4. Read accepted, then RESETB asserted the next cycle -> no rsp_valid; all outputs 0; the first request after reset wins for req0.
5. BIT_WIDTH=8, write addr 0x0018 data 0x00AB, read addr 0x001F -> ram_ada low 3 bits ignored by the DPB; rsp_data=0x00AB.
6. DPB_ARB_CLEAR_EN defined, memory preloaded nonzero -> ready held 0 for DEPTH cycles, init_done rises, then reads of word 0 and word DEPTH-1 return 0.

Source files
------------

// File: rtl/dpb_port_arbiter_if.sv
// dpb_port_arbiter_if: request/response channels of the two requesters plus
// the DPB port A pins. The slave modport is the arbiter's view; the master
// modport is the view of the client logic / RAM side.
interface dpb_port_arbiter_if;
  logic        req0_valid, req0_ready, req0_we;
  logic [13:0] req0_addr;
  logic [15:0] req0_wdata;
  logic        rsp0_valid;
  logic [15:0] rsp0_data;

  logic        req1_valid, req1_ready, req1_we;
  logic [13:0] req1_addr;
  logic [15:0] req1_wdata;
  logic        rsp1_valid;
  logic [15:0] rsp1_data;

  logic        ram_cea, ram_wrea, ram_ocea, ram_reseta;
  logic [13:0] ram_ada;
  logic [15:0] ram_dia;
  logic [2:0]  ram_blksel;
  logic [15:0] ram_doa;

  logic        init_done;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  ram_doa,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output ram_cea, ram_wrea, ram_ocea, ram_reseta, ram_ada, ram_dia, ram_blksel,
    output init_done
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output ram_doa,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  ram_cea, ram_wrea, ram_ocea, ram_reseta, ram_ada, ram_dia, ram_blksel,
    input  init_done
  );
endinterface

// File: rtl/dpb_port_arbiter.sv
// dpb_port_arbiter: round-robin share of DPB port A between two requesters.
// One registered RAM command per CLKA cycle; read data is routed back to the
// issuing requester one cycle after the command reaches the RAM.
// Optional macro DPB_ARB_CLEAR_EN: zero the whole RAM after every reset
// before accepting requests.
module dpb_port_arbiter #(
  parameter int         BIT_WIDTH = 16,
  parameter logic [2:0] BLK_SEL   = 3'b000
) (
  input logic               CLKA,
  input logic               RESETB,
  dpb_port_arbiter_if.slave bus
);
`ifdef DPB_ARB_CLEAR_EN
  localparam int SH    = $clog2(BIT_WIDTH);
  localparam int DEPTH = 2 ** (14 - SH);
`endif
  // DOA bits above BIT_WIDTH carry nothing meaningful; hand back zeros there.
  localparam logic [16:0] DATA_MASK = (17'd1 << BIT_WIDTH) - 17'd1;

  typedef enum logic [1:0] {ST_RST = 2'd0, ST_CLEAR = 2'd1, ST_RUN = 2'd2} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last_grant;          // requester that won the last accept
  logic        r_cea, r_wrea, r_owner;
  logic [13:0] r_ada;
  logic [15:0] r_dia;
  logic        r_rsp0_valid, r_rsp1_valid;

  logic        w_gnt0, w_gnt1;
  logic        w_cmd_vld, w_cmd_we, w_cmd_owner;
  logic [13:0] w_cmd_ada;
  logic [15:0] w_cmd_dia;
`ifdef DPB_ARB_CLEAR_EN
  logic [13:0] r_idx, w_idx_nxt;
`endif

  // Next state, grant decision and the command to register at the next edge
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_cmd_vld   = 1'b0;
    w_cmd_we    = 1'b0;
    w_cmd_owner = r_owner;
    w_cmd_ada   = r_ada;   // address/data hold when nothing is accepted
    w_cmd_dia   = r_dia;
`ifdef DPB_ARB_CLEAR_EN
    w_idx_nxt   = r_idx;
`endif
    case (r_state)
      ST_RST: begin
`ifdef DPB_ARB_CLEAR_EN
        w_state_nxt = ST_CLEAR;
`else
        w_state_nxt = ST_RUN;
`endif
      end
`ifdef DPB_ARB_CLEAR_EN
      ST_CLEAR: begin
        w_cmd_vld = 1'b1;
        w_cmd_we  = 1'b1;
        w_cmd_ada = r_idx << SH;
        w_cmd_dia = '0;
        if (r_idx == 14'(DEPTH - 1)) w_state_nxt = ST_RUN;
        else                         w_idx_nxt   = r_idx + 14'd1;
      end
`endif
      ST_RUN: begin
        // On a tie the requester that did not win last time goes first.
        w_gnt0 = bus.req0_valid & (~bus.req1_valid |  r_last_grant);
        w_gnt1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
        if (w_gnt0) begin
          w_cmd_vld   = 1'b1;
          w_cmd_we    = bus.req0_we;
          w_cmd_ada   = bus.req0_addr;
          w_cmd_dia   = bus.req0_wdata;
          w_cmd_owner = 1'b0;
        end else if (w_gnt1) begin
          w_cmd_vld   = 1'b1;
          w_cmd_we    = bus.req1_we;
          w_cmd_ada   = bus.req1_addr;
          w_cmd_dia   = bus.req1_wdata;
          w_cmd_owner = 1'b1;
        end
      end
      default: w_state_nxt = ST_RST;
    endcase
  end

  // FSM state register (and clear counter when present)
  always_ff @(posedge CLKA) begin
    if (RESETB) begin
      r_state <= ST_RST;
`ifdef DPB_ARB_CLEAR_EN
      r_idx   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
`ifdef DPB_ARB_CLEAR_EN
      r_idx   <= w_idx_nxt;
`endif
    end
  end

  // Registered RAM command, grant history and read-response tracking
  always_ff @(posedge CLKA) begin
    if (RESETB) begin
      r_last_grant <= 1'b1;
      r_cea        <= 1'b0;
      r_wrea       <= 1'b0;
      r_ada        <= '0;
      r_dia        <= '0;
      r_owner      <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      r_cea   <= w_cmd_vld;
      r_wrea  <= w_cmd_vld & w_cmd_we;
      r_ada   <= w_cmd_ada;
      r_dia   <= w_cmd_dia;
      r_owner <= w_cmd_owner;
      if (w_gnt0 | w_gnt1) r_last_grant <= w_gnt1;
      // The read on the bus this cycle is captured by the DPB at this edge.
      r_rsp0_valid <= r_cea & ~r_wrea & ~r_owner;
      r_rsp1_valid <= r_cea & ~r_wrea &  r_owner;
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp0_data  = bus.ram_doa & DATA_MASK[15:0];
  assign bus.rsp1_data  = bus.ram_doa & DATA_MASK[15:0];
  assign bus.ram_cea    = r_cea;
  assign bus.ram_wrea   = r_wrea;
  assign bus.ram_ocea   = 1'b1;
  assign bus.ram_reseta = 1'b0;
  assign bus.ram_ada    = r_ada;
  assign bus.ram_dia    = r_dia;
  assign bus.ram_blksel = BLK_SEL;
  assign bus.init_done  = (r_state == ST_RUN);
endmodule

// File: tb/tb_dpb_port_arbiter.sv
// tb_dpb_port_arbiter: directed checks of dpb_port_arbiter at BIT_WIDTH 16
// and 8, each driving a behavioural DPB port A model.
module tb_dpb_port_arbiter;
  logic CLKA = 1'b0;
  logic RESETB;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 CLKA = ~CLKA;

  dpb_port_arbiter_if b16 ();
  dpb_port_arbiter_if b8 ();

  dpb_port_arbiter #(.BIT_WIDTH(16), .BLK_SEL(3'b000)) u_dut16 (
    .CLKA(CLKA), .RESETB(RESETB), .bus(b16));
  dpb_port_arbiter #(.BIT_WIDTH(8), .BLK_SEL(3'b101)) u_dut8 (
    .CLKA(CLKA), .RESETB(RESETB), .bus(b8));

  // DPB port A models, preloaded nonzero; DOA updates on the edge that sees a read.
  logic [15:0] mem16 [0:1023] = '{default: 16'hFFFF};
  logic [7:0]  mem8  [0:2047] = '{default: 8'hFF};

  always @(posedge CLKA)
    if (b16.ram_cea) begin
      if (b16.ram_wrea) mem16[b16.ram_ada[13:4]] <= b16.ram_dia;
      else              b16.ram_doa <= mem16[b16.ram_ada[13:4]];
    end

  always @(posedge CLKA)
    if (b8.ram_cea) begin
      if (b8.ram_wrea) mem8[b8.ram_ada[13:3]] <= b8.ram_dia[7:0];
      else             b8.ram_doa <= {8'h00, mem8[b8.ram_ada[13:3]]};
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLKA);
    #1;
  endtask

  task automatic do_reset();
    int cyc, n16, rdy_seen;
    bit d16, d8;
    RESETB = 1'b1;
    step();
    chk("rst_drop_rsp0", b16.rsp0_valid, 0);
    chk("rst_drop_rsp1", b16.rsp1_valid, 0);
    step();
    chk("rst_cea",  b16.ram_cea,    0);
    chk("rst_wrea", b16.ram_wrea,   0);
    chk("rst_ada",  b16.ram_ada,    0);
    chk("rst_dia",  b16.ram_dia,    0);
    chk("rst_rsp0", b16.rsp0_valid, 0);
    chk("rst_rsp1", b16.rsp1_valid, 0);
    chk("rst_init", b16.init_done,  0);
    chk("rst_init8", b8.init_done,  0);
    RESETB = 1'b0;
    // Contend during init: no ready may appear before init_done.
    b16.req0_valid = 1'b1; b16.req0_we = 1'b0; b16.req0_addr = 14'h0;
    b16.req1_valid = 1'b1; b16.req1_we = 1'b0; b16.req1_addr = 14'h0;
    #1;
    cyc = 0; n16 = 0; rdy_seen = 0; d16 = 0; d8 = 0;
    while (!(d16 && d8) && cyc < 5000) begin
      if (!d16) begin
        if (b16.init_done) begin
          d16 = 1; n16 = cyc;
`ifdef DPB_ARB_CLEAR_EN
          chk("clr_last_cea",  b16.ram_cea,  1);
          chk("clr_last_wrea", b16.ram_wrea, 1);
          chk("clr_last_ada",  b16.ram_ada,  14'h3FF0);
          chk("clr_last_dia",  b16.ram_dia,  0);
`else
          chk("init_cea", b16.ram_cea, 0);
`endif
          b16.req0_valid = 1'b0; b16.req1_valid = 1'b0;
        end else if (b16.req0_ready || b16.req1_ready) rdy_seen++;
      end
      if (!d8 && b8.init_done) d8 = 1;
      if (!(d16 && d8)) begin
        step();
        cyc++;
      end
    end
    chk("init_timeout", {30'd0, d16, d8}, 3);
`ifdef DPB_ARB_CLEAR_EN
    chk("init_cycles", n16, 1025);
`else
    chk("init_cycles", n16, 1);
`endif
    chk("init_no_ready", rdy_seen, 0);
    b16.req0_valid = 1'b0; b16.req1_valid = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETB = 1'b1;
    b16.req0_valid = 0; b16.req0_we = 0; b16.req0_addr = '0; b16.req0_wdata = '0;
    b16.req1_valid = 0; b16.req1_we = 0; b16.req1_addr = '0; b16.req1_wdata = '0;
    b8.req0_valid  = 0; b8.req0_we  = 0; b8.req0_addr  = '0; b8.req0_wdata  = '0;
    b8.req1_valid  = 0; b8.req1_we  = 0; b8.req1_addr  = '0; b8.req1_wdata  = '0;
    do_reset();
    chk("const_ocea",   b16.ram_ocea,   1);
    chk("const_reseta", b16.ram_reseta, 0);
    chk("const_blksel", b8.ram_blksel,  3'b101);

    // 1: req0 write 0x0010=BEEF, then read it back.
    b16.req0_valid = 1; b16.req0_we = 1; b16.req0_addr = 14'h0010; b16.req0_wdata = 16'hBEEF;
    #1;
    chk("t1_wr_rdy0", b16.req0_ready, 1);
    chk("t1_wr_rdy1", b16.req1_ready, 0);
    step();
    chk("t1_wr_cea",  b16.ram_cea,  1);
    chk("t1_wr_wrea", b16.ram_wrea, 1);
    chk("t1_wr_ada",  b16.ram_ada,  14'h0010);
    chk("t1_wr_dia",  b16.ram_dia,  16'hBEEF);
    b16.req0_we = 0;
    #1;
    chk("t1_rd_rdy0", b16.req0_ready, 1);
    step();
    b16.req0_valid = 0;
    chk("t1_rsp_early", b16.rsp0_valid, 0);
    chk("t1_rd_wrea",   b16.ram_wrea,   0);
    step();
    chk("t1_rsp0_v", b16.rsp0_valid, 1);
    chk("t1_rsp0_d", b16.rsp0_data,  16'hBEEF);
    chk("t1_rsp1_v", b16.rsp1_valid, 0);
    step();
    chk("t1_rsp0_once", b16.rsp0_valid, 0);
    chk("t1_idle_cea",  b16.ram_cea,    0);
    chk("t1_hold_ada",  b16.ram_ada,    14'h0010);

    // 2: req1 writes 0x0000=5A5A, then both read continuously for 4 cycles.
    b16.req1_valid = 1; b16.req1_we = 1; b16.req1_addr = 14'h0000; b16.req1_wdata = 16'h5A5A;
    #1;
    chk("t2_wr_rdy1", b16.req1_ready, 1);
    step();
    b16.req0_valid = 1; b16.req0_we = 0; b16.req0_addr = 14'h0000;
    b16.req1_valid = 1; b16.req1_we = 0; b16.req1_addr = 14'h0010;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin b16.req0_valid = 0; b16.req1_valid = 0; end
      #1;
      if (i < 4) begin
        chk("t2_rdy0", b16.req0_ready, (i % 2) == 0);
        chk("t2_rdy1", b16.req1_ready, (i % 2) == 1);
      end
      step();
      if (i >= 1) begin
        chk("t2_rsp0_v", b16.rsp0_valid, ((i - 1) % 2) == 0);
        chk("t2_rsp1_v", b16.rsp1_valid, ((i - 1) % 2) == 1);
        if (((i - 1) % 2) == 0) chk("t2_rsp0_d", b16.rsp0_data, 16'h5A5A);
        else                    chk("t2_rsp1_d", b16.rsp1_data, 16'hBEEF);
      end
    end

    // 3: make last_grant=0, then req1 write and req0 read of 0x0020 together.
    b16.req0_valid = 1; b16.req0_addr = 14'h0000;
    #1; step();
    b16.req0_valid = 0;
    step(); step();
    b16.req1_valid = 1; b16.req1_we = 1; b16.req1_addr = 14'h0020; b16.req1_wdata = 16'h1234;
    b16.req0_valid = 1; b16.req0_we = 0; b16.req0_addr = 14'h0020;
    #1;
    chk("t3_rdy1_first", b16.req1_ready, 1);
    chk("t3_rdy0_wait",  b16.req0_ready, 0);
    step();
    b16.req1_valid = 0;
    #1;
    chk("t3_rdy0_next", b16.req0_ready, 1);
    step();
    b16.req0_valid = 0;
    chk("t3_rd_ada",  b16.ram_ada,  14'h0020);
    chk("t3_rd_wrea", b16.ram_wrea, 0);
    step();
    chk("t3_rsp0_v", b16.rsp0_valid, 1);
    chk("t3_rsp0_d", b16.rsp0_data,  16'h1234);
    chk("t3_rsp1_v", b16.rsp1_valid, 0);

    // 4: read accepted, reset the next cycle; then req0 wins the first tie.
    b16.req0_valid = 1; b16.req0_we = 0; b16.req0_addr = 14'h0010;
    #1; step();
    b16.req0_valid = 0;
    do_reset();
    b16.req0_valid = 1; b16.req0_we = 0; b16.req0_addr = 14'h0010;
    b16.req1_valid = 1; b16.req1_we = 0; b16.req1_addr = 14'h0000;
    #1;
    chk("t4_rdy0", b16.req0_ready, 1);
    chk("t4_rdy1", b16.req1_ready, 0);
    step();
    b16.req0_valid = 0; b16.req1_valid = 0;
    step();
    chk("t4_rsp0_v", b16.rsp0_valid, 1);
    chk("t4_rsp1_v", b16.rsp1_valid, 0);
`ifdef DPB_ARB_CLEAR_EN
    chk("t4_rsp0_d", b16.rsp0_data, 16'h0000);
`else
    chk("t4_rsp0_d", b16.rsp0_data, 16'hBEEF);
`endif
    step();

    // 5: BIT_WIDTH=8, write 0x0018=AB, read 0x001F (same word).
    b8.req0_valid = 1; b8.req0_we = 1; b8.req0_addr = 14'h0018; b8.req0_wdata = 16'h00AB;
    #1;
    chk("t5_wr_rdy0", b8.req0_ready, 1);
    step();
    b8.req0_we = 0; b8.req0_addr = 14'h001F;
    #1;
    chk("t5_rd_rdy0", b8.req0_ready, 1);
    step();
    b8.req0_valid = 0;
    chk("t5_rd_ada", b8.ram_ada, 14'h001F);
    step();
    chk("t5_rsp0_v", b8.rsp0_valid, 1);
    chk("t5_rsp0_d", b8.rsp0_data,  16'h00AB);

`ifdef DPB_ARB_CLEAR_EN
    // 6: after a clearing reset, first and last words read back as zero.
    do_reset();
    b16.req0_valid = 1; b16.req0_we = 0; b16.req0_addr = 14'h0000;
    #1; step();
    b16.req0_addr = 14'h3FF0;
    #1; step();
    b16.req0_valid = 0;
    chk("t6_w0_v", b16.rsp0_valid, 1);
    chk("t6_w0_d", b16.rsp0_data,  16'h0000);
    step();
    chk("t6_wlast_v", b16.rsp0_valid, 1);
    chk("t6_wlast_d", b16.rsp0_data,  16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
